// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential multi-digit BCD-to-binary converter (reverse double dabble).
// Each CONV cycle shifts {bcd_sr, bin_sr} right one bit and then subtracts 3 from
// every BCD nibble that is >= 8. After BIN_W shifts the binary value sits in bin_sr.
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN (reject nibbles > 9 with err).

// Per-digit correction after a right shift: a nibble >= 8 received a carried
// "ten" from the digit above, worth 5 here after halving, so fold it back by -3.
module bcd_to_bin_nib_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;
endmodule

module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                    state;
  logic [4*DIGITS-1:0]       bcd_sr;
  logic [BIN_W-1:0]          bin_sr;
  logic [CNT_W-1:0]          cnt;

  logic [DIGITS-1:0][3:0]    bcd_shift;
  logic [DIGITS-1:0][3:0]    bcd_adj;
  logic [BIN_W-1:0]          bin_nxt;

  // Datapath for one iteration: the LSB of the BCD register falls into the
  // top of the binary register, then each nibble is corrected independently.
  assign bcd_shift = bcd_sr >> 1;
  assign bin_nxt   = {bcd_sr[0], bin_sr[BIN_W-1:1]};

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_to_bin_nib_adj u_adj (
      .din  (bcd_shift[d]),
      .dout (bcd_adj[d])
    );
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic [DIGITS-1:0] bad_nib;
  logic              bad_digit;
  logic              err_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_chk
    assign bad_nib[d] = (bcd_in[4*d +: 4] > 4'd9);
  end
  assign bad_digit = |bad_nib;
  assign err       = err_q;
`else
  assign err = 1'b0;
`endif

  // Control FSM with registered outputs; rst wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      bcd_sr  <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (bad_digit) begin
              // Invalid word: report immediately, never enter CONV.
              state   <= DONE;
              done    <= 1'b1;
              err_q   <= 1'b1;
              bin_out <= '0;
            end else
`endif
            begin
              bcd_sr <= bcd_in;
              bin_sr <= '0;
              cnt    <= CNT_W'(BIN_W);
              busy   <= 1'b1;
              state  <= CONV;
            end
          end else begin
            state <= IDLE;
          end
        end
        CONV: begin
          bcd_sr <= bcd_adj;
          bin_sr <= bin_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bin_out <= bin_nxt;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: table-driven and scoreboard checks for bcd_to_bin (DIGITS=4, BIN_W=14).
// Build with +define+BCD2BIN_DIGIT_CHECK_EN to also exercise the invalid-digit path.
module tb_bcd_to_bin;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       bcd_in = '0;
  logic              busy, done, err;
  logic [BIN_W-1:0]  bin_out;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  typedef struct {
    logic [15:0]      bcd;
    logic [BIN_W-1:0] bin;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) @cyc %0d", name, act, act, req, req, cyc);
    end
  endtask

  task automatic push(input logic [BIN_W-1:0] b, input logic e);
    exp_t x;
    x.bin = b;
    x.err = e;
    sbq.push_back(x);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_done", done, 0);
      else begin
        e = sbq.pop_front();
        chk("bin_out", bin_out, e.bin);
        chk("err", err, e.err);
      end
    end
  end

  // One isolated conversion; done_k is the negedge index (1 = right after the
  // accept edge) where done must appear. poke re-pulses start mid-conversion.
  task automatic convert(input logic [15:0] b, input logic [BIN_W-1:0] eb, input logic ee,
                         input int done_k, input int poke);
    int k, nb;
    push(eb, ee);
    @(negedge clk); bcd_in = b; start = 1'b1;
    @(negedge clk); start = 1'b0; k = 1; nb = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) nb++;
      if (poke != 0 && k == poke) begin start = 1'b1; bcd_in = 16'h0999; end
      else start = 1'b0;
      @(negedge clk); k++;
    end
    start = 1'b0;
    chk("done_latency", k, done_k);
    chk("busy_cycles", nb, done_k - 1);
    @(negedge clk);
    chk("hold_bin_out", bin_out, eb);
    chk("done_one_cycle", done, 0);
  endtask

  vec_t tbl[10];
  int   vals[$];
  int   k, t1, t2;

  initial begin
    tbl[0] = '{16'h1234, 14'd1234};
    tbl[1] = '{16'h9999, 14'd9999};
    tbl[2] = '{16'h0000, 14'd0};
    tbl[3] = '{16'h0001, 14'd1};
    tbl[4] = '{16'h0010, 14'd10};
    tbl[5] = '{16'h0100, 14'd100};
    tbl[6] = '{16'h1000, 14'd1000};
    tbl[7] = '{16'h0809, 14'd809};
    tbl[8] = '{16'h8000, 14'd8000};
    tbl[9] = '{16'h5678, 14'd5678};

    // Reset held for two edges.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    foreach (tbl[i]) convert(tbl[i].bcd, tbl[i].bin, 1'b0, 15, 0);

    // start pulsed while busy must not disturb result or timing.
    convert(16'h0321, 14'd321, 1'b0, 15, 5);
    repeat (20) @(negedge clk);
    chk("idle_after_poke", busy, 0);

    // start held high: back-to-back conversions, done pulses 15 cycles apart.
    push(14'd42, 1'b0);
    @(negedge clk); bcd_in = 16'h0042; start = 1'b1;
    @(negedge clk); bcd_in = 16'h0007; push(14'd7, 1'b0);
    k = 1;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk("b2b_first_latency", k, 15);
    t1 = cyc;
    @(negedge clk); start = 1'b0; k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    t2 = cyc;
    chk("b2b_spacing", t2 - t1, 15);
    repeat (3) @(negedge clk);

    // Reset mid-conversion: abort, no done, bin_out cleared.
    @(negedge clk); bcd_in = 16'h5678; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_bin_out", bin_out, 0);
    chk("abort_done", done, 0);
    repeat (20) @(negedge clk);
    chk("abort_still_idle", busy, 0);
    convert(16'h0010, 14'd10, 1'b0, 15, 0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    convert(16'h12A4, 14'd0, 1'b1, 1, 0);
    convert(16'h0099, 14'd99, 1'b0, 15, 0);
`endif

    // Strided back-to-back sweep across the decimal range.
    for (int v = 0; v < 10000; v += 7) vals.push_back(v);
    vals.push_back(9999);
    @(negedge clk); bcd_in = to_bcd(vals[0]); start = 1'b1; push(14'(vals[0]), 1'b0);
    for (int i = 1; i <= vals.size(); i++) begin
      @(negedge clk);
      k = 0;
      while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      chk("sweep_latency", k, 14);
      if (i < vals.size()) begin
        bcd_in = to_bcd(vals[i]);
        push(14'(vals[i]), 1'b0);
      end else start = 1'b0;
    end
    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
